// File: rtl/cmp6_arbiter.sv
// rtl/cmp6_arbiter.sv - round-robin shared WIDTH-bit eq/neq comparator with 4-phase req/ack.
// Optional transaction statistics (true_cnt) enabled by defining CMP_ARB_STATS_EN.
module cmp6_arbiter #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             sel0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic             sel1,
  output logic             ack0,
  output logic             ack1,
  output logic             result,
  output logic [1:0]       grant,
  output logic             busy
`ifdef CMP_ARB_STATS_EN
  ,
  output logic [7:0]       true_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_owner;
  logic             r_last_grant;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_sel;

  logic w_any;
  logic w_pick;
  logic w_owner_req;
  logic w_eq;
  logic w_cmp;

  // On a tie the requester that was not served last wins.
  assign w_any       = req0 | req1;
  assign w_pick      = (req0 && req1) ? ~r_last_grant : req1;
  assign w_owner_req = r_owner ? req1 : req0;
  assign w_eq        = (r_a == r_b);
  assign w_cmp       = r_sel ? ~w_eq : w_eq;
  assign busy        = (r_state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any) w_next = CMP;
      CMP:     w_next = DONE;
      DONE:    if (!w_owner_req) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack0         <= 1'b0;
      ack1         <= 1'b0;
      result       <= 1'b0;
      grant        <= 2'b00;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_a          <= '0;
      r_b          <= '0;
      r_sel        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_owner <= w_pick;
            grant   <= w_pick ? 2'b10 : 2'b01;
            r_a     <= w_pick ? a1 : a0;
            r_b     <= w_pick ? b1 : b0;
            r_sel   <= w_pick ? sel1 : sel0;
          end
        end
        CMP: begin
          result <= w_cmp;
          ack0   <= ~r_owner;
          ack1   <= r_owner;
        end
        DONE: begin
          // A req dropped early still gets exactly one cycle of ack.
          if (!w_owner_req) begin
            ack0         <= 1'b0;
            ack1         <= 1'b0;
            grant        <= 2'b00;
            r_last_grant <= r_owner;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CMP_ARB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      true_cnt <= 8'h00;
    end else if (r_state == CMP && w_cmp && true_cnt != 8'hFF) begin
      true_cnt <= true_cnt + 8'h01;
    end
  end
`endif

endmodule
